// File: rtl/wb_write_buffer.sv
// Writeback buffer in front of the register file: queues ALU and load results
// in order, drains one per cycle, and forwards pending values to decode.
module wb_write_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [N-1:0]  alu_data,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_data,
  output logic          stall,
  output logic          overflow,
  output logic          rf_write_enable,
  output logic [AW-1:0] rf_write_addr,
  output logic [N-1:0]  rf_write_data,
  input  logic [AW-1:0] fwd_addr1,
  input  logic [AW-1:0] fwd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [N-1:0]  fwd_data1,
  output logic [N-1:0]  fwd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [N-1:0]     data_q [DEPTH];

  logic          pop, take_mem, take_alu, dropped;
  logic          we0, we1;
  logic [PW-1:0] slot0, slot1;
  logic [AW-1:0] wa0;
  logic [N-1:0]  wd0;
  logic [1:0]    n_push;
  logic [CW:0]   space;

  assign pop = (count_q != '0);

  // The slot being popped counts as free, so a full buffer still takes one push.
  always_comb begin
    space    = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    take_mem = mem_valid && (space >= (CW+1)'(1));
    take_alu = alu_valid && (space >= (take_mem ? (CW+1)'(2) : (CW+1)'(1)));
    dropped  = (mem_valid && !take_mem) || (alu_valid && !take_alu);
    n_push   = {1'b0, take_mem} + {1'b0, take_alu};
    we0      = take_mem || take_alu;
    we1      = take_mem && take_alu;
    wa0      = take_mem ? mem_addr : alu_addr;
    wd0      = take_mem ? mem_data : alu_data;
    slot0    = wr_ptr_q;
    slot1    = wr_ptr_q + PW'(1);
  end

  always_comb begin
    valid_d = valid_q;
    if (pop) valid_d[rd_ptr_q] = 1'b0;
    if (we0) valid_d[slot0] = 1'b1;
    if (we1) valid_d[slot1] = 1'b1;
    wr_ptr_d   = wr_ptr_q + PW'(n_push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(n_push) - CW'(pop);
    overflow_d = overflow_q || dropped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (we0 && (slot0 == PW'(i))) begin
          addr_q[i] <= wa0;
          data_q[i] <= wd0;
        end else if (we1 && (slot1 == PW'(i))) begin
          addr_q[i] <= alu_addr;
          data_q[i] <= alu_data;
        end
      end
    end
  end

  assign stall           = (count_q >= CW'(DEPTH - 1));
  assign overflow        = overflow_q;
  assign rf_write_enable = pop;
  assign rf_write_addr   = pop ? addr_q[rd_ptr_q] : '0;
  assign rf_write_data   = pop ? data_q[rd_ptr_q] : '0;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == fwd_addr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (valid_q[idx] && (addr_q[idx] == fwd_addr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end

endmodule
